// File: rtl/aes_pkg.sv
// Shared AES types, tables and byte/word/state helpers for the iterative cipher.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3][0:3] state_t;  // [column][row]; [0][0] is the MSB byte

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Out-of-range indices yield zero so idle-state lookups stay defined.
  function automatic byte_t rcon_at(logic [3:0] i);
    return (i >= 4'd1 && i <= 4'd10) ? RCON[i] : 8'h00;
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic state_t to_state(logic [127:0] d);
    return state_t'(d);
  endfunction

  function automatic logic [127:0] from_state(state_t s);
    return 128'(s);
  endfunction

  function automatic state_t shift_rows(state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[2'(c)][2'(r)] = s[2'(c + r)][2'(r)];
    return o;
  endfunction

  function automatic state_t mix_columns(state_t s);
    state_t o;
    byte_t a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[2'(c)][0];
      a1 = s[2'(c)][1];
      a2 = s[2'(c)][2];
      a3 = s[2'(c)][3];
      o[2'(c)][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[2'(c)][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[2'(c)][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[2'(c)][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One 4-word key-schedule step: rot selects RotWord+Rcon, else SubWord only.
  function automatic logic [127:0] expand_key(logic [127:0] prev, logic [31:0] last,
                                              byte_t rcon, logic rot);
    logic [31:0] t, w0, w1, w2, w3;
    t  = rot ? (sub_word(rot_word(last)) ^ {rcon, 24'h0}) : sub_word(last);
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] next_state
);

  state_t s_in, s_sub, s_shift;

  assign s_in = to_state(state);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign s_sub[c][r] = SBOX[s_in[c][r]];
    end
  end

  assign s_shift    = shift_rows(s_sub);
  assign next_state = from_state(last_round ? s_shift : mix_columns(s_shift)) ^ round_key;

endmodule

// File: rtl/aes_encr_iter.sv
// Iterative AES-128/256 encryption engine, one round per clock with on-the-fly key expansion.
module aes_encr_iter
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        ip_data,
  input  logic [KEY_BITS-1:0] ip_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        encr_data_out
);

  localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_encr_iter: KEY_BITS must be 128 or 256");
  end

  logic [1:0]          state_q, state_d;
  logic [3:0]          round_q, round_d;
  logic [127:0]        data_q, data_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [127:0]        dout_q, dout_d;

  logic [127:0]        round_key;
  logic [KEY_BITS-1:0] key_step;
  logic [127:0]        round_out;

  // AES-256 keeps the last two round keys; the low half is the key for the current round.
  if (KEY_BITS == 256) begin : g_k256
    logic [127:0] fresh;
    assign round_key = key_q[127:0];
    assign fresh     = expand_key(key_q[255:128], key_q[31:0],
                                  rcon_at(4'((round_q + 4'd1) >> 1)), round_q[0]);
    assign key_step  = {key_q[127:0], fresh};
  end else begin : g_k128
    assign round_key = expand_key(key_q, key_q[31:0], rcon_at(round_q), 1'b1);
    assign key_step  = round_key;
  end

  aes_round u_round (
    .state      (data_q),
    .round_key  (round_key),
    .last_round (round_q == 4'(NR)),
    .next_state (round_out)
  );

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    data_d      = data_q;
    key_d       = key_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d     = ip_data ^ ip_key[KEY_BITS-1 -: 128];
          key_d      = ip_key;
          round_d    = 4'd1;
          in_ready_d = 1'b0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        data_d  = round_out;
        key_d   = key_step;
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          dout_d      = round_out;
          out_valid_d = 1'b1;
          round_d     = 4'd0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      data_q      <= 128'h0;
      key_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= 128'h0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      data_q      <= data_d;
      key_q       <= key_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign encr_data_out = dout_q;

endmodule

// File: tb/tb_aes_encr_iter.sv
// Bench for aes_encr_iter: AES-128 and AES-256 instances against a FIPS-197 style reference model.
module tb_aes_encr_iter;

  logic         clk;
  logic         rst;
  logic         in_valid_s  [2];
  logic         in_ready_s  [2];
  logic [127:0] ip_data_s   [2];
  logic [255:0] kin         [2];
  logic         out_valid_s [2];
  logic         out_ready_s [2];
  logic [127:0] dout_s      [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb_m [256];

  aes_encr_iter #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .ip_data(ip_data_s[0]), .ip_key(kin[0][255:128]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .encr_data_out(dout_s[0])
  );

  aes_encr_iter #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .ip_data(ip_data_s[1]), .ip_key(kin[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .encr_data_out(dout_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = 8'(x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from multiplicative inverse plus affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] model_enc(logic [127:0] pt, logic [255:0] key, int nk);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a [4];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sb_m[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c + r] = t[4*((c + r) % 4) + r];
        if (rnd < nr) begin
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[4*c + r];
            s[4*c+0] = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
            s[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
            s[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
            s[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c + r] = s[4*c + r] ^ w[4*rnd + c][31 - 8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send(input int sel, input logic [127:0] pt, input logic [255:0] key);
    @(negedge clk);
    in_valid_s[sel] = 1'b1;
    ip_data_s[sel]  = pt;
    kin[sel]        = key;
    @(negedge clk);
    in_valid_s[sel] = 1'b0;
  endtask

  task automatic wait_out(input int sel, output int lat, output logic [127:0] d, output bit to);
    lat = 0;
    to  = 1'b0;
    while (out_valid_s[sel] !== 1'b1) begin
      if (lat >= 64) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    d = dout_s[sel];
  endtask

  task automatic drain(input int sel);
    out_ready_s[sel] = 1'b1;
    @(negedge clk);
    out_ready_s[sel] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid_s[s] = 1'b0; out_ready_s[s] = 1'b0;
      ip_data_s[s] = 128'h0; kin[s] = 256'h0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (in_ready_s[s] !== 1'b1) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", s, in_ready_s[s]);
      end
      n_tests++;
      if (out_valid_s[s] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", s, out_valid_s[s]);
      end
      n_tests++;
      if (dout_s[s] !== 128'h0) begin
        n_fail++; $display("FAIL reset_data[%0d]: got %h expected 0", s, dout_s[s]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_fips();
    logic [127:0] pts [3];
    logic [255:0] keys [3];
    logic [127:0] exps [3];
    int sels [3];
    int lat;
    logic [127:0] d;
    bit to;
    pts[0] = 128'h3243f6a8885a308d313198a2e0370734;
    keys[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    exps[0] = 128'h3925841d02dc09fbdc118597196a0b32; sels[0] = 0;
    pts[1] = 128'h00112233445566778899aabbccddeeff;
    keys[1] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    exps[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; sels[1] = 0;
    pts[2] = 128'h00112233445566778899aabbccddeeff;
    keys[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    exps[2] = 128'h8ea2b7ca516745bfeafc49904b496089; sels[2] = 1;
    for (int v = 0; v < 3; v++) begin
      send(sels[v], pts[v], keys[v]);
      wait_out(sels[v], lat, d, to);
      n_tests++;
      if (to || lat != (sels[v] == 1 ? 14 : 10)) begin
        n_fail++; $display("FAIL fips%0d_latency: got %0d (timeout %0d) expected %0d",
                           v, lat, to, sels[v] == 1 ? 14 : 10);
      end
      n_tests++;
      if (d !== exps[v]) begin
        n_fail++; $display("FAIL fips%0d_data: got %h expected %h", v, d, exps[v]);
      end
      drain(sels[v]);
      n_tests++;
      if (in_ready_s[sels[v]] !== 1'b1 || out_valid_s[sels[v]] !== 1'b0) begin
        n_fail++; $display("FAIL fips%0d_release: in_ready %b out_valid %b expected 1 0",
                           v, in_ready_s[sels[v]], out_valid_s[sels[v]]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] d, pt, exp;
    logic [255:0] key;
    bit to;
    for (int i = 0; i < 24; i++) begin
      int s;
      s   = i % 2;
      pt  = rand128();
      key = {rand128(), rand128()};
      exp = model_enc(pt, key, s == 1 ? 8 : 4);
      send(s, pt, key);
      wait_out(s, lat, d, to);
      n_tests++;
      if (to || lat != (s == 1 ? 14 : 10) || d !== exp) begin
        n_fail++; $display("FAIL random%0d[%0d]: got %h lat %0d expected %h lat %0d",
                           i, s, d, lat, exp, s == 1 ? 14 : 10);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drain(s);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] d, pt, exp;
    logic [255:0] key;
    bit to, seen;
    pt  = rand128();
    key = {rand128(), rand128()};
    exp = model_enc(pt, key, 4);
    send(0, pt, key);
    wait_out(0, lat, d, to);
    n_tests++;
    if (to || d !== exp) begin
      n_fail++; $display("FAIL bp_first: got %h expected %h", d, exp);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid_s[0] = (c == 7);
      if (c == 7) ip_data_s[0] = ~pt;
      @(negedge clk);
      n_tests++;
      if (out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0 || dout_s[0] !== exp) begin
        n_fail++; $display("FAIL bp_hold%0d: valid %b ready %b data %h expected 1 0 %h",
                           c, out_valid_s[0], in_ready_s[0], dout_s[0], exp);
      end
    end
    in_valid_s[0] = 1'b0;
    drain(0);
    n_tests++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid %b ready %b expected 0 1",
                         out_valid_s[0], in_ready_s[0]);
    end
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid_s[0] === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL bp_no_ghost: got out_valid 1 expected 0");
    end
  endtask

  task automatic test_input_changes();
    int lat;
    logic [127:0] pt, exp;
    logic [255:0] key;
    for (int s = 0; s < 2; s++) begin
      pt  = rand128();
      key = {rand128(), rand128()};
      exp = model_enc(pt, key, s == 1 ? 8 : 4);
      send(s, pt, key);
      in_valid_s[s] = 1'b1;
      lat = 0;
      while (out_valid_s[s] !== 1'b1 && lat < 64) begin
        ip_data_s[s] = rand128();
        kin[s]       = {rand128(), rand128()};
        @(negedge clk);
        lat++;
      end
      in_valid_s[s] = 1'b0;
      n_tests++;
      if (lat != (s == 1 ? 14 : 10) || dout_s[s] !== exp) begin
        n_fail++; $display("FAIL churn[%0d]: got %h lat %0d expected %h lat %0d",
                           s, dout_s[s], lat, exp, s == 1 ? 14 : 10);
      end
      drain(s);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [127:0] d;
    bit to;
    logic [127:0] pt  = 128'h3243f6a8885a308d313198a2e0370734;
    logic [255:0] key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    logic [127:0] exp = 128'h3925841d02dc09fbdc118597196a0b32;
    send(0, pt, key);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || dout_s[0] !== 128'h0) begin
      n_fail++; $display("FAIL midreset_async: valid %b ready %b data %h expected 0 1 0",
                         out_valid_s[0], in_ready_s[0], dout_s[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    n_tests++;
    if (out_valid_s[0] !== 1'b0 || dout_s[0] !== 128'h0) begin
      n_fail++; $display("FAIL midreset_hold: valid %b data %h expected 0 0",
                         out_valid_s[0], dout_s[0]);
    end
    send(0, pt, key);
    wait_out(0, lat, d, to);
    n_tests++;
    if (to || lat != 10 || d !== exp) begin
      n_fail++; $display("FAIL midreset_fresh: got %h lat %0d expected %h lat 10", d, lat, exp);
    end
    drain(0);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_backpressure();
    test_input_changes();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_encr_iter.md
Name: aes_encr_iter

Overview:
- Iterative AES encryption engine: one round per clock, with on-the-fly key expansion.
- Parametrised for AES-128 or AES-256 key length.
- Valid/ready handshakes on input and output, so it drops into streaming datapaths.
- Next-generation encryption core for the AES128 codebase: adds key-size selection, flow control and deterministic latency.

Parameters:
- KEY_BITS, 128: cipher key width. Legal values are 128 and 256; any other value is an elaboration-time $error.
- NR, derived (10 when KEY_BITS=128, 14 when 256): number of rounds. Localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, active-low, asynchronous.
- in_valid  input  1  plaintext/key pair valid.
- in_ready  output  1  engine can accept a pair.
- ip_data  input  128  plaintext block; byte 0 = bits [127:120], column-major per FIPS-197.
- ip_key  input  KEY_BITS  cipher key; byte 0 at MSB.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  downstream accepts ciphertext.
- encr_data_out  output  128  ciphertext, same byte order as ip_data.

Behaviour:
- Clock and reset: single clock domain, clk. rst is asynchronous and active-low.
- Reset values (rst low): state=IDLE, in_ready=1, out_valid=0, encr_data_out=0, round counter=0, internal state and key registers=0.
- Reset mid-operation: any block in flight is discarded and no output is produced. The first acceptance after reset release is on the first rising edge with rst high.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge:
    - state_reg <= ip_data ^ first 128 key bits (initial AddRoundKey).
    - Key registers load ip_key.
    - round <= 1.
    - Go to BUSY.
  - BUSY: in_ready=0; in_valid is ignored. Each edge applies one round to state_reg with round key `round`, derived from the key registers on the fly.
    - Rounds 1..NR-1: SubBytes, ShiftRows, MixColumns, AddRoundKey.
    - Round NR omits MixColumns.
    - After round NR: encr_data_out <= result, out_valid <= 1, go to DONE.
  - DONE: out_valid=1. encr_data_out is held stable while out_ready=0. On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- Latency: out_valid rises exactly NR edges after the accept edge (10 for AES-128, 14 for AES-256). Minimum initiation interval is NR+2 cycles; there is no back-to-back overlap.
- Key schedule, AES-128: each round key = previous words expanded with RotWord/SubWord/Rcon[round].
- Key schedule, AES-256: two 128-bit halves are kept.
  - Odd rounds use the second half of the original/previous pair.
  - Even rounds generate a new half with RotWord/SubWord/Rcon[round/2].
  - Odd-index generations use SubWord only, no Rcon.
  - Key expansion must match FIPS-197 words w[4r..4r+3].
- Rcon: bytes 01,02,04,08,10,20,40,80,1B,36. The index never exceeds 10 for AES-128 or 7 for AES-256.
- GF(2^8) arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00). All datapaths are 8-bit per byte, no widening.
- Simultaneous events:
  - in_valid asserted in DONE is not accepted; in_ready stays 0 until IDLE.
  - out_ready asserted without out_valid has no effect.
- ip_data/ip_key are sampled only at the accept edge; later changes are ignored.

Decomposition:
- Package aes_pkg:
  - typedef byte_t (logic [7:0]);
  - typedef state_t (byte_t [0:3][0:3]);
  - constant SBOX[256];
  - constant RCON[1:10];
  - functions xtime, sub_word, rot_word, shift_rows, mix_columns, to_state/from_state.
- Sub-module aes_round (combinational):
  - inputs state, round_key, last_round;
  - output next state;
  - contains 16 S-box lookups.
- The top holds the FSM, round counter and key-schedule registers.

Test Plan:
- FIPS-197 App. B, KEY_BITS=128: ip_data=3243f6a8885a308d313198a2e0370734, ip_key=2b7e151628aed2a6abf7158809cf4f3c → encr_data_out=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
- FIPS-197 App. C.1, KEY_BITS=128: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. C.3, KEY_BITS=256: same pt, key=000102…1e1f → 8ea2b7ca516745bfeafc49904b496089, out_valid 14 edges after accept.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → encr_data_out stable, in_ready=0 throughout, and a new in_valid pulse in that window is not consumed. Raise out_ready → one transfer, then in_ready=1 on the next cycle.
- Input changes during BUSY: change ip_data/ip_key every cycle after accept → ciphertext still equals the expected value for the pair sampled at the accept edge.
- Reset mid-operation: pull rst low at round 5 → out_valid=0, encr_data_out=0, in_ready=1 immediately (asynchronously). After release, a fresh App. B vector yields the correct result with no stale output.
